linreg_frame_ctrl: RTL and testbench

Frame-level sequencer for the `linear_regr` line-fit core. It gates the masked pixel stream from the tracking front end into the core and issues `tabulate` once per frame. It waits for the fit with a watchdog, qualifies the result against a minimum point count, and holds the last good line for downstream consumers. It sits between the pixel mask stage and the renderer; `linear_regr` is instantiated beside it by the parent.

---
 rtl/linreg_pkg.sv | 18 +
 rtl/linreg_frame_ctrl.sv | 131 +++++++++++++
 tb/tb_linreg_frame_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/linreg_pkg.sv
// Shared types and widths for the linear_regr frame sequencer.
package linreg_pkg;

    localparam int X_W   = 11;
    localparam int Y_W   = 10;
    localparam int A_W   = 18;
    localparam int B_W   = 25;
    localparam int CNT_W = 21;

    typedef enum logic [2:0] {
        COLLECT = 3'd0,
        TAB     = 3'd1,
        WAIT    = 3'd2,
        SETTLE  = 3'd3,
        FLUSH   = 3'd4
    } linreg_state_t;

endpackage

// File: rtl/linreg_frame_ctrl.sv
// Frame sequencer around linear_regr: forwards masked pixels, requests one fit
// per frame, guards the wait with a watchdog and holds the last qualified line.
module linreg_frame_ctrl
    import linreg_pkg::*;
#(
    parameter int MIN_POINTS     = 64,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [X_W-1:0]        pix_x_in,
    input  logic [Y_W-1:0]        pix_y_in,
    input  logic                  pix_valid_in,
    input  logic                  pix_mask_in,
    input  logic                  frame_end_in,
    output logic [X_W-1:0]        regr_x_out,
    output logic [Y_W-1:0]        regr_y_out,
    output logic                  regr_valid_out,
    output logic                  regr_tabulate_out,
    output logic                  regr_rst_out,
    input  logic signed [A_W-1:0] regr_a_in,
    input  logic signed [B_W-1:0] regr_b_in,
    input  logic                  regr_valid_in,
    output logic signed [A_W-1:0] line_a_out,
    output logic signed [B_W-1:0] line_b_out,
    output logic                  line_valid_out,
    output logic                  line_stale_out,
    output logic [CNT_W-1:0]      point_count_out,
    output logic                  timeout_err_out,
    output logic [7:0]            dropped_frames_out
);

    localparam int                WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  MIN_CNT = CNT_W'(MIN_POINTS);

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [7:0] sat_inc_drop(input logic [7:0] v);
        return (&v) ? v : v + 8'd1;
    endfunction

    linreg_state_t    state, state_next;
    logic [CNT_W-1:0] frame_cnt, frame_total;
    logic [WD_W-1:0]  wd_cnt;
    logic             flush_second;
    logic             pix_hit, frame_close, frame_drop;
    logic             result_good, result_short, wd_fire;

    // The frame total includes a pixel arriving together with frame_end_in.
    always_comb begin
        pix_hit      = pix_valid_in & pix_mask_in & (state == COLLECT);
        frame_total  = pix_hit ? sat_inc_cnt(frame_cnt) : frame_cnt;
        frame_close  = frame_end_in & (state == COLLECT);
        frame_drop   = frame_end_in & (state != COLLECT);
        result_good  = (state == WAIT) & regr_valid_in & (point_count_out >= MIN_CNT);
        result_short = (state == WAIT) & regr_valid_in & (point_count_out < MIN_CNT);
        wd_fire      = (state == WAIT) & ~regr_valid_in & (wd_cnt == WD_LAST);
        state_next   = state;
        case (state)
            COLLECT: if (frame_close && (frame_total != '0)) state_next = TAB;
            TAB:     state_next = WAIT;
            WAIT: begin
                if (regr_valid_in)             state_next = SETTLE;
                else if (wd_cnt == WD_LAST)    state_next = FLUSH;
            end
            SETTLE:  state_next = COLLECT;
            FLUSH:   if (flush_second) state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= COLLECT;
        else           state <= state_next;
    end

    // Stage p1: frame bookkeeping, core handshake and published line
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            frame_cnt          <= '0;
            wd_cnt             <= '0;
            flush_second       <= 1'b0;
            point_count_out    <= '0;
            dropped_frames_out <= '0;
            line_stale_out     <= 1'b1;
            line_a_out         <= '0;
            line_b_out         <= '0;
            line_valid_out     <= 1'b0;
            regr_tabulate_out  <= 1'b0;
            regr_rst_out       <= 1'b1;
            timeout_err_out    <= 1'b0;
            regr_x_out         <= '0;
            regr_y_out         <= '0;
            regr_valid_out     <= 1'b0;
        end else begin
            if (frame_close || (state != COLLECT)) frame_cnt <= '0;
            else if (pix_hit)                      frame_cnt <= sat_inc_cnt(frame_cnt);

            if (state == TAB)       wd_cnt <= '0;
            else if (state == WAIT) wd_cnt <= wd_cnt + WD_W'(1);

            flush_second <= (state == FLUSH) ? ~flush_second : 1'b0;

            if (frame_close) point_count_out <= frame_total;
            if (frame_drop)  dropped_frames_out <= sat_inc_drop(dropped_frames_out);

            if (result_good) begin
                line_a_out     <= regr_a_in;
                line_b_out     <= regr_b_in;
                line_stale_out <= 1'b0;
            end else if (result_short || wd_fire || (frame_close && (frame_total == '0))) begin
                line_stale_out <= 1'b1;
            end

            line_valid_out    <= result_good;
            regr_tabulate_out <= (state == TAB);
            regr_rst_out      <= (state_next == FLUSH);
            timeout_err_out   <= wd_fire;

            regr_valid_out <= pix_hit;
            if (pix_hit) begin
                regr_x_out <= pix_x_in;
                regr_y_out <= pix_y_in;
            end
        end
    end

endmodule

// File: tb/tb_linreg_frame_ctrl.sv
// Bench for linreg_frame_ctrl: randomized frames against a frame-level model
// of the sequencer, with a programmable-latency core stub.
module tb_linreg_frame_ctrl;
    import linreg_pkg::*;

    localparam int MIN_PTS = 64;
    localparam int TMO     = 96;

    logic                  clk_in = 1'b0;
    logic                  rst_n_in = 1'b0;
    logic [X_W-1:0]        pix_x_in = '0;
    logic [Y_W-1:0]        pix_y_in = '0;
    logic                  pix_valid_in = 1'b0;
    logic                  pix_mask_in = 1'b0;
    logic                  frame_end_in = 1'b0;
    logic [X_W-1:0]        regr_x_out;
    logic [Y_W-1:0]        regr_y_out;
    logic                  regr_valid_out;
    logic                  regr_tabulate_out;
    logic                  regr_rst_out;
    logic signed [A_W-1:0] regr_a_in;
    logic signed [B_W-1:0] regr_b_in;
    logic                  regr_valid_in = 1'b0;
    logic signed [A_W-1:0] line_a_out;
    logic signed [B_W-1:0] line_b_out;
    logic                  line_valid_out;
    logic                  line_stale_out;
    logic [CNT_W-1:0]      point_count_out;
    logic                  timeout_err_out;
    logic [7:0]            dropped_frames_out;

    linreg_frame_ctrl #(.MIN_POINTS(MIN_PTS), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .pix_x_in(pix_x_in), .pix_y_in(pix_y_in), .pix_valid_in(pix_valid_in),
        .pix_mask_in(pix_mask_in), .frame_end_in(frame_end_in),
        .regr_x_out(regr_x_out), .regr_y_out(regr_y_out), .regr_valid_out(regr_valid_out),
        .regr_tabulate_out(regr_tabulate_out), .regr_rst_out(regr_rst_out),
        .regr_a_in(regr_a_in), .regr_b_in(regr_b_in), .regr_valid_in(regr_valid_in),
        .line_a_out(line_a_out), .line_b_out(line_b_out), .line_valid_out(line_valid_out),
        .line_stale_out(line_stale_out), .point_count_out(point_count_out),
        .timeout_err_out(timeout_err_out), .dropped_frames_out(dropped_frames_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int failures = 0;

    // Event monitor, sampled mid-cycle.
    int          cyc = 0, n_tab = 0, n_lv = 0, n_tout = 0, n_rstc = 0, n_fwd = 0, n_coinc = 0;
    int          tab_cyc = 0, lv_cyc = 0, tout_cyc = 0, rst_rise_cyc = 0;
    logic        rst_prev = 1'b1;
    logic [31:0] fwd_sum = '0;

    always @(negedge clk_in) begin
        cyc = cyc + 1;
        if (regr_tabulate_out) begin n_tab = n_tab + 1; tab_cyc = cyc; end
        if (line_valid_out)    begin n_lv = n_lv + 1; lv_cyc = cyc; end
        if (timeout_err_out)   begin n_tout = n_tout + 1; tout_cyc = cyc; end
        if (regr_rst_out && rst_n_in) n_rstc = n_rstc + 1;
        if (regr_rst_out && !rst_prev) rst_rise_cyc = cyc;
        rst_prev = regr_rst_out;
        if (regr_valid_out) begin
            n_fwd   = n_fwd + 1;
            fwd_sum = fwd_sum + 32'({regr_x_out, regr_y_out});
            if (regr_tabulate_out) n_coinc = n_coinc + 1;
        end
    end

    // Core stub: answers stub_lat cycles after tabulate; stub_lat == 0 never answers.
    int                    stub_lat = 0, stub_cnt = 0;
    logic signed [A_W-1:0] stub_a = '0;
    logic signed [B_W-1:0] stub_b = '0;
    assign regr_a_in = stub_a;
    assign regr_b_in = stub_b;

    always @(negedge clk_in) begin
        regr_valid_in = 1'b0;
        if (!rst_n_in) stub_cnt = 0;
        else if (regr_tabulate_out && stub_lat != 0) stub_cnt = stub_lat;
        else if (stub_cnt != 0) begin
            stub_cnt = stub_cnt - 1;
            if (stub_cnt == 0) regr_valid_in = 1'b1;
        end
    end

    // Frame-level reference model state.
    logic signed [A_W-1:0] exp_a = '0;
    logic signed [B_W-1:0] exp_b = '0;
    logic                  exp_stale = 1'b1;
    int                    exp_drop = 0;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic v, input logic m, input logic fe,
                        input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        pix_valid_in = v; pix_mask_in = m; frame_end_in = fe; pix_x_in = x; pix_y_in = y;
        @(posedge clk_in); #1;
        pix_valid_in = 1'b0; pix_mask_in = 1'b0; frame_end_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic send_frame(input int npts, input bit coinc, output int fe_c, output logic [31:0] sum);
        int sent = 0;
        sum = '0;
        fe_c = 0;
        while (sent < npts) begin
            logic [X_W-1:0] x;
            logic [Y_W-1:0] y;
            logic           k;
            x = X_W'($urandom);
            y = Y_W'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                k = 1'($urandom_range(0, 1));
                beat(k, ~k, 1'b0, x, y);
            end else begin
                sent = sent + 1;
                if (sent == npts && coinc) begin
                    fe_c = cyc + 1;
                    beat(1'b1, 1'b1, 1'b1, x, y);
                end else begin
                    beat(1'b1, 1'b1, 1'b0, x, y);
                end
                sum = sum + 32'({x, y});
            end
        end
        if (npts == 0 || !coinc) begin
            fe_c = cyc + 1;
            beat(1'b0, 1'b0, 1'b1, '0, '0);
        end
    endtask

    task automatic run_frame(input string tag, input int npts, input bit coinc, input int lat);
        int          tab0, lv0, f0, c0, fe_c;
        logic [31:0] s0, sum;
        tab0 = n_tab; lv0 = n_lv; f0 = n_fwd; c0 = n_coinc; s0 = fwd_sum;
        stub_lat = lat;
        send_frame(npts, coinc, fe_c, sum);
        idle(lat + 8);
        if (npts >= MIN_PTS) begin
            exp_a = stub_a; exp_b = stub_b; exp_stale = 1'b0;
        end else begin
            exp_stale = 1'b1;
        end
        chk({tag, "_count"}, point_count_out, npts);
        chk({tag, "_fwd_n"}, n_fwd - f0, npts);
        chk({tag, "_fwd_sum"}, fwd_sum - s0, sum);
        chk({tag, "_tab_n"}, n_tab - tab0, (npts > 0) ? 1 : 0);
        chk({tag, "_lv_n"}, n_lv - lv0, (npts >= MIN_PTS) ? 1 : 0);
        chk({tag, "_line_a"}, line_a_out, exp_a);
        chk({tag, "_line_b"}, line_b_out, exp_b);
        chk({tag, "_stale"}, line_stale_out, exp_stale);
        chk({tag, "_overlap"}, n_coinc - c0, 0);
        if (npts > 0) chk({tag, "_tab_lat"}, tab_cyc - fe_c, 2);
        if (npts >= MIN_PTS) chk({tag, "_res_lat"}, lv_cyc - tab_cyc, lat + 1);
    endtask

    initial begin
        int          fe_c, f0, tab0, lv0, tout0, rst0, npts;
        logic [31:0] sum;

        // Reset values while held in reset
        idle(3);
        @(negedge clk_in);
        chk("rst_regr_rst", regr_rst_out, 1);
        chk("rst_stale", line_stale_out, 1);
        chk("rst_line_a", line_a_out, 0);
        chk("rst_line_b", line_b_out, 0);
        chk("rst_count", point_count_out, 0);
        chk("rst_dropped", dropped_frames_out, 0);
        chk("rst_tab", regr_tabulate_out, 0);
        chk("rst_fwd_valid", regr_valid_out, 0);
        chk("rst_line_valid", line_valid_out, 0);
        chk("rst_timeout", timeout_err_out, 0);
        @(posedge clk_in); #1;
        rst_n_in = 1'b1;
        @(negedge clk_in);
        chk("rel_regr_rst_held", regr_rst_out, 1);
        @(negedge clk_in);
        chk("rel_regr_rst_drop", regr_rst_out, 0);
        @(posedge clk_in); #1;

        // Normal frame, then a short one ending on its last pixel, then an empty one
        stub_a = 18'sd5; stub_b = 25'sd20;
        run_frame("normal", 100, 1'b0, 70);
        stub_a = 18'sd9; stub_b = 25'sd33;
        run_frame("few", 10, 1'b1, 20);
        stub_a = -18'sd7; stub_b = -25'sd1000;
        run_frame("good2", 64, 1'b1, 15);
        run_frame("empty", 0, 1'b0, 5);

        // Randomized frames
        for (int i = 0; i < 6; i++) begin
            stub_a = A_W'($urandom);
            stub_b = B_W'($urandom);
            npts = int'($urandom_range(0, 110));
            run_frame("rand", npts, 1'($urandom_range(0, 1)), int'($urandom_range(3, 80)));
        end

        // Frames arriving while busy are dropped, as are their pixels
        stub_a = 18'sd77; stub_b = -25'sd4;
        stub_lat = 60;
        send_frame(70, 1'b0, fe_c, sum);
        idle(10);
        f0 = n_fwd;
        beat(1'b1, 1'b1, 1'b1, 11'd3, 10'd4);
        beat(1'b1, 1'b1, 1'b0, 11'd5, 10'd6);
        beat(1'b0, 1'b0, 1'b1, '0, '0);
        exp_drop = exp_drop + 2;
        chk("busy_fwd_n", n_fwd - f0, 0);
        idle(60);
        exp_a = stub_a; exp_b = stub_b; exp_stale = 1'b0;
        chk("busy_dropped", dropped_frames_out, exp_drop);
        chk("busy_count", point_count_out, 70);
        chk("busy_line_a", line_a_out, exp_a);
        run_frame("after_busy", 66, 1'b0, 9);

        // Core never answers
        tab0 = n_tab; lv0 = n_lv; tout0 = n_tout; rst0 = n_rstc;
        stub_lat = 0;
        send_frame(70, 1'b0, fe_c, sum);
        idle(TMO + 12);
        exp_stale = 1'b1;
        chk("hang_tab_n", n_tab - tab0, 1);
        chk("hang_tout_n", n_tout - tout0, 1);
        chk("hang_tout_lat", tout_cyc - tab_cyc, TMO);
        chk("hang_rst_cycles", n_rstc - rst0, 2);
        chk("hang_rst_start", rst_rise_cyc, tout_cyc);
        chk("hang_lv_n", n_lv - lv0, 0);
        chk("hang_stale", line_stale_out, exp_stale);
        chk("hang_line_a", line_a_out, exp_a);
        run_frame("after_hang", 80, 1'b1, 25);

        // Reset asserted while waiting for the core
        stub_lat = 50;
        send_frame(80, 1'b0, fe_c, sum);
        idle(20);
        rst_n_in = 1'b0;
        #2;
        exp_a = '0; exp_b = '0; exp_stale = 1'b1; exp_drop = 0;
        chk("mid_rst_regr_rst", regr_rst_out, 1);
        chk("mid_rst_stale", line_stale_out, 1);
        chk("mid_rst_line_a", line_a_out, 0);
        chk("mid_rst_line_b", line_b_out, 0);
        chk("mid_rst_count", point_count_out, 0);
        chk("mid_rst_dropped", dropped_frames_out, 0);
        chk("mid_rst_tab", regr_tabulate_out, 0);
        idle(3);
        rst_n_in = 1'b1;
        idle(3);
        chk("mid_rst_release", regr_rst_out, 0);
        stub_a = 18'sd1234; stub_b = 25'sd99;
        run_frame("recover", 90, 1'b1, 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
